// File: rtl/reg_set_pkg.sv
// Shared defaults and RW encoding for the reg_set scratch register file.
package reg_set_pkg;

  localparam int unsigned DefDataWidth = 4;
  localparam int unsigned DefAddrWidth = 3;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/reg_set_word.sv
// One register-file entry: DATA_WIDTH register with asynchronous clear and load enable.
module reg_set_word #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] word_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_set.sv
// Eight-entry scratch register file: one shared address, RW=1 writes an entry, RW=0 loads it
// onto the registered Data_out, which otherwise holds.
module reg_set
  import reg_set_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  output logic [DATA_WIDTH-1:0] Data_out,
  input  logic                  Clk,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  RW,
  input  logic                  Reset
);

  logic [DEPTH-1:0]      we;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;

  // One-hot entry select, only live on write cycles.
  always_comb begin
    we = '0;
    if (RW == RW_WRITE) begin
      we[Address] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_set_word #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_word (
      .clk_i (Clk),
      .rst_i (Reset),
      .load_i(we[i]),
      .d_i   (Data_in),
      .q_o   (mem[i])
    );
  end

  // Read data is the entry as it stood before this edge; no write bypass.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_out_q <= '0;
    end else if (RW == RW_READ) begin
      data_out_q <= mem[Address];
    end
  end

  assign Data_out = data_out_q;

endmodule

// File: tb/tb_reg_set.sv
// Directed scoreboard bench for reg_set: expected Data_out is queued per step and checked after the edge.
module tb_reg_set;

  logic       Clk;
  logic       Reset;
  logic [3:0] Data_in;
  logic [2:0] Address;
  logic       RW;
  logic [3:0] Data_out;

  int checks;
  int errors;

  logic [3:0] exp_q[$];
  logic [3:0] model [8];
  logic [3:0] last_out;

  reg_set dut (
    .Data_out(Data_out),
    .Clk     (Clk),
    .Data_in (Data_in),
    .Address (Address),
    .RW      (RW),
    .Reset   (Reset)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag);
    logic [3:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h required <scoreboard entry>", tag, Data_out);
    end else begin
      exp = exp_q.pop_front();
      assert (Data_out === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h required %h", tag, Data_out, exp);
      end
    end
  endtask

  // Called at posedge+2; drives one operation, checks at the following posedge+1,
  // and returns at posedge+2.
  task automatic do_op(input logic rw, input logic [2:0] a, input logic [3:0] d,
                       input string tag);
    RW      = rw;
    Address = a;
    Data_in = d;
    if (rw) begin
      model[a] = d;
    end else begin
      last_out = model[a];
    end
    exp_q.push_back(last_out);
    @(posedge Clk);
    #1;
    check(tag);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 4'h0;
    last_out = 4'h0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset   = 1'b1;
    RW      = 1'b0;
    Address = 3'd0;
    Data_in = 4'h0;
    clear_model();

    #1;
    exp_q.push_back(4'h0);
    check("reset_state");

    @(posedge Clk);
    #2;
    Reset = 1'b0;

    for (int k = 0; k < 8; k++) do_op(1'b0, 3'(k), 4'h0, "read_after_reset");

    for (int k = 0; k < 8; k++) do_op(1'b1, 3'(k), 4'(k), "fill_hold");

    for (int k = 7; k >= 0; k--) do_op(1'b0, 3'(k), 4'h0, "readback_desc");

    do_op(1'b1, 3'd3, 4'hA, "write_a_hold");
    do_op(1'b0, 3'd3, 4'h0, "read_after_write");
    for (int k = 0; k < 8; k++) do_op(1'b0, 3'(k), 4'h0, "others_unchanged");

    do_op(1'b0, 3'd5, 4'h0, "read5");
    do_op(1'b1, 3'd0, 4'hF, "hold_during_write");
    do_op(1'b1, 3'd6, 4'h9, "hold_second_write");
    do_op(1'b0, 3'd0, 4'h0, "read_new0");
    do_op(1'b0, 3'd0, 4'h0, "repeat_read0");

    // Mid-cycle asynchronous reset; a write attempted while held must be ignored.
    Reset = 1'b1;
    clear_model();
    #1;
    exp_q.push_back(4'h0);
    check("async_reset_immediate");
    RW      = 1'b1;
    Address = 3'd2;
    Data_in = 4'h7;
    @(posedge Clk);
    #1;
    exp_q.push_back(4'h0);
    check("reset_held_over_edge");
    #1;
    Reset = 1'b0;
    RW    = 1'b0;

    for (int k = 0; k < 8; k++) do_op(1'b0, 3'(k), 4'h0, "read_after_midreset");

    do_op(1'b1, 3'd4, 4'hC, "post_reset_write");
    do_op(1'b0, 3'd4, 4'h0, "post_reset_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
